// File: rtl/mem_wb_regfile_if.sv
// rtl/mem_wb_regfile_if.sv - memory-stage to write-back bus, read ports and status
// Purpose: bundles every non-clock/reset signal of mem_wb_regfile.
//   master : driven by the pipeline (memory stage, hazard control, decode reads)
//   slave  : the write-back stage / register file
// Signals:
//   mem_out_data, mem_rd, mem_reg_write, mem_valid : incoming memory-stage result
//   stall, flush                                   : MEM/WB latch control
//   rs_addr, rt_addr / rs_data, rt_data            : two combinational read ports
//   wb_data, wb_rd, wb_reg_write                   : latched write-back bus for forwarding
//   retire_count                                   : committed register writes since reset
interface mem_wb_regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
);
  logic [DATA_W-1:0] mem_out_data;
  logic [ADDR_W-1:0] mem_rd;
  logic              mem_reg_write;
  logic              mem_valid;
  logic              stall;
  logic              flush;
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic [DATA_W-1:0] wb_data;
  logic [ADDR_W-1:0] wb_rd;
  logic              wb_reg_write;
  logic [CNT_W-1:0]  retire_count;

  modport master (
    output mem_out_data, mem_rd, mem_reg_write, mem_valid, stall, flush, rs_addr, rt_addr,
    input  rs_data, rt_data, wb_data, wb_rd, wb_reg_write, retire_count
  );

  modport slave (
    input  mem_out_data, mem_rd, mem_reg_write, mem_valid, stall, flush, rs_addr, rt_addr,
    output rs_data, rt_data, wb_data, wb_rd, wb_reg_write, retire_count
  );
endinterface

// File: rtl/mem_wb_regfile.sv
// rtl/mem_wb_regfile.sv - MEM/WB pipeline latch with 2R/1W register file and retire counter
// Purpose: latches the memory-stage result, commits it to the register file one edge later,
//   exposes the latched bus for forwarding and counts committed writes.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; clears latch, register array and counter
//   bus   : mem_wb_regfile_if.slave (see interface file for the signal list)
// Optional feature: define WB_BYPASS_EN to let the read ports see the value being
//   committed in the same cycle; otherwise reads return the array contents only.
module mem_wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic clk,
  input  logic reset,
  mem_wb_regfile_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];

  logic [DATA_W-1:0] wb_data_q;
  logic [ADDR_W-1:0] wb_rd_q;
  logic              wb_we_q;
  logic              wb_valid_q;
  logic              wb_done_q;
  logic [CNT_W-1:0]  retire_q;
  logic              commit;

  // wb_done marks a held (stalled) entry that has already been written, so a long
  // stall commits and counts it exactly once.
  assign commit = wb_valid_q & wb_we_q & (wb_rd_q != '0) & ~wb_done_q;

  // MEM/WB latch: flush beats stall; flush only squashes the incoming instruction,
  // the pre-edge entry still commits through the register-file process below.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_data_q  <= '0;
      wb_rd_q    <= '0;
      wb_we_q    <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_done_q  <= 1'b0;
    end else if (bus.flush) begin
      wb_data_q  <= '0;
      wb_rd_q    <= '0;
      wb_we_q    <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_done_q  <= 1'b0;
    end else if (bus.stall) begin
      if (commit) begin
        wb_done_q <= 1'b1;
      end
    end else begin
      wb_data_q  <= bus.mem_out_data;
      wb_rd_q    <= bus.mem_rd;
      wb_we_q    <= bus.mem_reg_write;
      wb_valid_q <= bus.mem_valid;
      wb_done_q  <= 1'b0;
    end
  end

  // Register array and retire counter; index 0 is never written because commit
  // already excludes wb_rd == 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      retire_q <= '0;
    end else if (commit) begin
      regs[wb_rd_q] <= wb_data_q;
      retire_q      <= retire_q + CNT_W'(1);
    end
  end

  always_comb begin
    bus.rs_data = '0;
    bus.rt_data = '0;
    if (bus.rs_addr != '0) begin
      bus.rs_data = regs[bus.rs_addr];
    end
    if (bus.rt_addr != '0) begin
      bus.rt_data = regs[bus.rt_addr];
    end
`ifdef WB_BYPASS_EN
    // commit implies wb_rd != 0, so register 0 still reads as zero
    if (commit && (bus.rs_addr == wb_rd_q)) begin
      bus.rs_data = wb_data_q;
    end
    if (commit && (bus.rt_addr == wb_rd_q)) begin
      bus.rt_data = wb_data_q;
    end
`else
`endif
  end

  assign bus.wb_data      = wb_data_q;
  assign bus.wb_rd        = wb_rd_q;
  assign bus.wb_reg_write = commit;
  assign bus.retire_count = retire_q;

endmodule

// File: doc/mem_wb_regfile.md
Name: mem_wb_regfile

Overview:
- Write-back stage directly downstream of the data memory stage.
- Captures the memory stage's selected result (load data or ALU result), its destination register and its write enable into a MEM/WB pipeline latch.
- Commits the latched result to a 2-read/1-write general-purpose register file one cycle later.
- Exposes the latched write-back bus for EX-stage forwarding and keeps a retired-write counter.

Parameters:
- DATA_W, 32, register and data width.
- ADDR_W, 5, register index width; the file holds 2**ADDR_W entries.
- CNT_W, 32, width of the retired-write counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- mem_out_data  in  DATA_W  result from the memory stage (load data or passed-through ALU result).
- mem_rd  in  ADDR_W  destination register of the memory-stage instruction.
- mem_reg_write  in  1  memory-stage instruction writes a register.
- mem_valid  in  1  memory stage holds a real instruction (0 = bubble).
- stall  in  1  hold the MEM/WB latch.
- flush  in  1  squash the instruction entering the latch.
- rs_addr  in  ADDR_W  read port A index.
- rt_addr  in  ADDR_W  read port B index.
- rs_data  out  DATA_W  read port A data, combinational.
- rt_data  out  DATA_W  read port B data, combinational.
- wb_data  out  DATA_W  latched write-back data, for forwarding.
- wb_rd  out  ADDR_W  latched destination register.
- wb_reg_write  out  1  latched entry is valid, write-enabled, not yet committed, and wb_rd != 0.
- retire_count  out  CNT_W  number of register writes committed since reset.

Behaviour:
- Reset (asynchronous, active-high):
  - Register array cleared to 0.
  - Latch state cleared: wb_valid=0, wb_done=0, wb_data=0, wb_rd=0, wb_we=0.
  - retire_count=0; rs_data, rt_data and wb_reg_write therefore read 0.
- Latch update at each rising edge, in priority order:
  - flush=1: wb_valid<=0, wb_done<=0; data, rd and we are don't-care but are loaded as 0. Flush wins over stall.
  - else stall=1: latch holds all fields.
  - else: wb_data<=mem_out_data, wb_rd<=mem_rd, wb_we<=mem_reg_write, wb_valid<=mem_valid, wb_done<=0.
- Commit condition: commit = wb_valid & wb_we & (wb_rd!=0) & ~wb_done.
- At each rising edge where commit=1:
  - regs[wb_rd]<=wb_data.
  - retire_count<=retire_count+1.
  - If stall=1, wb_done<=1 so the held entry is never written or counted twice.
  - The commit uses the pre-edge latch contents even when flush or a new load occurs on the same edge; flush squashes only the incoming instruction.
- Latency: a result presented at edge N is latched at N and visible in the array after edge N+1.
- wb_reg_write equals commit, combinational from latch state.
- Register 0: writes to index 0 are never performed; reads of index 0 always return 0.
- Read ports: rs_data and rt_data are combinational from the address inputs.
- retire_count wraps modulo 2**CNT_W with no saturation.
- Same-address writes on consecutive edges: the later write wins.
- Reset asserted mid-stall or mid-commit: all state is cleared immediately and no commit occurs on that edge.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: each read port returns wb_data when commit=1 and the port address equals wb_rd (address nonzero). Otherwise it returns regs[addr]. A same-cycle read of the register being committed sees the new value.
- Undefined: read ports return regs[addr] only. The new value is visible only after the commit edge, and the EX stage must forward from wb_data/wb_rd instead.

Test Plan:
- Reset: assert reset mid-cycle with latch loaded → all outputs 0 immediately; rs_addr=5 after release returns 0.
- Basic write-back: mem_valid=1, mem_reg_write=1, mem_rd=8, mem_out_data=0xDEADBEEF for one cycle → wb_reg_write=1 the next cycle; after the following edge, rs_addr=8 gives 0xDEADBEEF and retire_count=1.
- Register zero: mem_rd=0, mem_out_data=0x12345678, write enabled → wb_reg_write=0, rt_addr=0 reads 0, retire_count unchanged.
- Stall: load rd=3, data=0xAA, then hold stall=1 for 4 cycles → regs[3]=0xAA after the first edge, retire_count incremented exactly once, wb_reg_write=0 for the remaining stalled cycles.
- Flush: rd=4 committing while a new rd=5 instruction (data 0x55) enters with flush=1 → regs[4] written, regs[5] unchanged, wb_valid=0 next cycle; with stall=1 and flush=1 together, the flush still clears the latch.
- Bypass: with rs_addr=9 while wb latch holds rd=9, data=0x77 uncommitted → rs_data=0x77 with WB_BYPASS_EN defined, or the old regs[9] value without it, changing to 0x77 after the edge.
